accum_out_arbiter: RTL

- Round-robin arbiter that merges the output queues of NUM_LANES accumulator last stages into one registered stream for the write-back stage.
- Pops lane queues using their rd_ready/rd_en handshake and discards invalid (valid-bit 0) entries.
- Tracks end-of-pass: asserts all_done once every lane has ended and everything has drained.
- Counts the records emitted in each pass.

---
 rtl/accum_out_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/accum_out_arbiter.sv
// Round-robin merge of NUM_LANES accumulator output queues into one registered stream,
// with end-of-pass tracking and a per-pass emitted-record counter.
`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 64
`endif

module accum_out_arbiter #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned BITS_LANE  = 2,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH_ADD_STG,
  parameter int unsigned BITS_CNT   = 32
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            en_global,
  input  logic [NUM_LANES-1:0]            lane_rd_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_do,
  input  logic [NUM_LANES-1:0]            lane_data_ended,
  output logic [NUM_LANES-1:0]            lane_rd_en,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [BITS_LANE-1:0]            out_lane,
  output logic [BITS_CNT-1:0]             out_count,
  output logic                            all_done
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [BITS_LANE-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [BITS_LANE-1:0]  out_lane_q, out_lane_d;
  logic [BITS_CNT-1:0]   out_count_q, out_count_d;
  logic                  all_done_q, all_done_d;

  logic                  slot_free, grant, gnt_found, load_valid, all_ended, cnt_clr;
  logic [BITS_LANE-1:0]  gnt_idx, cand_idx;
  logic [DATA_WIDTH-1:0] head;

  assign slot_free = !out_valid_q || out_ready;
  assign all_ended = &lane_data_ended;

  // First ready lane at or after rr_ptr, modulo NUM_LANES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand_idx = BITS_LANE'((32'(rr_ptr_q) + i) % NUM_LANES);
      if (!gnt_found && lane_rd_ready[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (gnt_idx == BITS_LANE'(i)) head = lane_do[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant      = en_global && slot_free && gnt_found;
  assign lane_rd_en = grant ? (NUM_LANES'(1) << gnt_idx) : '0;
  assign load_valid = grant && head[0];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gnt_idx == BITS_LANE'(NUM_LANES - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Invalid heads are popped but never loaded; the slot only empties on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    if (load_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = head;
      out_lane_d  = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      StRun: begin
        if (all_ended) state_d = StDrain;
      end
      StDrain: begin
        if (!all_ended) begin
          state_d = StRun;
        end else if (!(|lane_rd_ready) && !out_valid_q && !grant) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!all_ended) begin
          state_d = StRun;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign all_done_d = (state_q == StDone) && all_ended;

  always_comb begin
    out_count_d = out_count_q;
    if (cnt_clr) begin
      out_count_d = '0;
    end else if (out_valid_q && out_ready && (out_count_q != '1)) begin
      out_count_d = out_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StRun;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_count_q <= '0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_count_q <= out_count_d;
      all_done_q  <= all_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_count = out_count_q;
  assign all_done  = all_done_q;

endmodule
